comparator_bist: RTL and testbench

Synthesizable stimulus-and-check engine for the `comparator` block. It sits on the input side of the comparator: it drives every `(a, b)` operand pair, then samples the `greater`/`equal`/`less` flags that come back. It checks those flags against an internal unsigned reference and reports a pass/fail summary. It is used for on-board self-test and as a reusable bench driver.

---
 rtl/comparator_bist.sv | 170 +++++++++++++++++
 tb/tb_comparator_bist.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/comparator_bist.sv
// comparator_bist -- stimulus-and-check engine for a magnitude comparator.
//
// Sweeps every (a, b) operand pair, holds each pair for SETTLE_CYCLES
// cycles, then samples the greater/equal/less flags. Each sample is checked
// against an unsigned reference {a>b, a==b, a<b}, and the engine reports a
// pass/fail summary.
//
// Parameters:
//   WIDTH          operand width (default 4)
//   SETTLE_CYCLES  cycles the operands are held before sampling (>= 1)
//
// Ports:
//   clk, rst                          clock; synchronous active-high reset
//   start                             begin a sweep (ignored while busy)
//   a_out, b_out                      operands driven to the comparator
//   greater_in, equal_in, less_in     flags returned by the comparator
//   busy, done                        sweep running / sweep finished
//   pass                              done and err_count == 0
//   err_count                         number of failing vectors
//   fail_valid, fail_a, fail_b        first failing vector
//
// Optional feature macro: CMP_BIST_FIRST_FAIL_EN builds the first-failure
// capture. Without it, fail_valid, fail_a and fail_b are tied to 0.
module comparator_bist #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic               greater_in,
  input  logic               equal_in,
  input  logic               less_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] v_q, v_d;
  logic [SW-1:0]      settle_q, settle_d;
  logic [2*WIDTH:0]   err_q, err_d;

  logic [WIDTH-1:0] a_cur, b_cur;
  logic [2:0]       exp_flags, got_flags;
  logic             start_sweep, err_hit;

  assign a_cur       = v_q[2*WIDTH-1:WIDTH];
  assign b_cur       = v_q[WIDTH-1:0];
  assign exp_flags   = {a_cur > b_cur, a_cur == b_cur, a_cur < b_cur};
  assign got_flags   = {greater_in, equal_in, less_in};
  // A full 3-bit compare also catches non-one-hot flag patterns.
  assign err_hit     = (state_q == S_CHECK) && (got_flags != exp_flags);
  assign start_sweep = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;

  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    settle_d = settle_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_DRIVE;
          v_d      = '0;
          settle_d = '0;
          err_d    = '0;
        end
      end
      S_DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = S_CHECK;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (err_hit) err_d = err_q + 1'b1;
        // The last vector is left on the operands while in DONE.
        if (v_q == {2*WIDTH{1'b1}}) begin
          state_d = S_DONE;
        end else begin
          v_d     = v_q + 1'b1;
          state_d = S_DRIVE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      v_q      <= '0;
      settle_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      settle_q <= settle_d;
      err_q    <= err_d;
    end
  end

  assign a_out     = a_cur;
  assign b_out     = b_cur;
  assign busy      = (state_q == S_DRIVE) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;

`ifdef CMP_BIST_FIRST_FAIL_EN
  logic             fv_q, fv_d;
  logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;

  always_comb begin
    fv_d = fv_q;
    fa_d = fa_q;
    fb_d = fb_q;
    if (start_sweep) begin
      fv_d = 1'b0;
      fa_d = '0;
      fb_d = '0;
    end else if (err_hit && !fv_q) begin
      fv_d = 1'b1;
      fa_d = a_cur;
      fb_d = b_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fv_q <= 1'b0;
      fa_q <= '0;
      fb_q <= '0;
    end else begin
      fv_q <= fv_d;
      fa_q <= fa_d;
      fb_q <= fb_d;
    end
  end

  assign fail_valid = fv_q;
  assign fail_a     = fa_q;
  assign fail_b     = fb_q;
`else
  // start_sweep only feeds the capture logic.
  logic unused_start_sweep;
  assign unused_start_sweep = start_sweep;
  assign fail_valid = 1'b0;
  assign fail_a     = '0;
  assign fail_b     = '0;
`endif

endmodule

// File: tb/tb_comparator_bist.sv
// Bench for comparator_bist (WIDTH=4, SETTLE_CYCLES=1).
//
// The comparator is modelled inline: correct, equal stuck at 0, or
// greater/less swapped. Each sweep's hand-computed outcome is queued when
// start is issued. A monitor pops it on the rising edge of done and checks
// the counts, the first-failure capture and the start-to-done latency.
module tb_comparator_bist;
  localparam int W = 4;
  localparam int LAT = 512;
`ifdef CMP_BIST_FIRST_FAIL_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] a_out, b_out, fail_a, fail_b;
  logic greater_in, equal_in, less_in;
  logic busy, done, pass, fail_valid;
  logic [2*W:0] err_count;

  int mode = 0;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int err;
    int pass;
    int fv;
    int fa;
    int fb;
    int start_edge;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comparator_bist #(.WIDTH(W), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_out(a_out), .b_out(b_out),
    .greater_in(greater_in), .equal_in(equal_in), .less_in(less_in),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_a(fail_a), .fail_b(fail_b)
  );

  // Comparator model: 0 correct, 1 equal stuck at 0, 2 greater/less swapped.
  always_comb begin
    greater_in = a_out > b_out;
    equal_in   = a_out == b_out;
    less_in    = a_out < b_out;
    if (mode == 1) equal_in = 1'b0;
    if (mode == 2) begin
      greater_in = a_out < b_out;
      less_in    = a_out > b_out;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " pass"}, int'(pass), 0);
    chk({tag, " err_count"}, int'(err_count), 0);
    chk({tag, " a_out"}, int'(a_out), 0);
    chk({tag, " b_out"}, int'(b_out), 0);
    chk({tag, " fail_valid"}, int'(fail_valid), 0);
    chk({tag, " fail_a"}, int'(fail_a), 0);
    chk({tag, " fail_b"}, int'(fail_b), 0);
  endtask

  // Pulse start at the next edge and check the first cycle of the sweep.
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy after start", int'(busy), 1);
    chk("done after start", int'(done), 0);
    chk("a_out after start", int'(a_out), 0);
    chk("b_out after start", int'(b_out), 0);
  endtask

  task automatic run_sweep(input int m, input int e_err, input int e_fa,
                           input int e_fb, input bit repulse);
    exp_t e;
    int k;
    mode = m;
    tick();
    e.err = e_err;
    e.pass = (e_err == 0) ? 1 : 0;
    e.fv = (FF_EN && e_err != 0) ? 1 : 0;
    e.fa = FF_EN ? e_fa : 0;
    e.fb = FF_EN ? e_fb : 0;
    e.start_edge = cyc + 1;
    sb.push_back(e);
    pulse_start();
    if (repulse) begin
      repeat (98) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy after ignored start", int'(busy), 1);
    end
    k = 0;
    while (!done && k < 2000) begin
      tick();
      k++;
    end
    if (!done) chk("done timeout", 0, 1);
    repeat (3) tick();
  endtask

  // Scoreboard monitor: one queued expectation per completed sweep.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    done_prev <= done;
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        chk("unexpected done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", cyc - e.start_edge, LAT);
        chk("err_count", int'(err_count), e.err);
        chk("pass", int'(pass), e.pass);
        chk("fail_valid", int'(fail_valid), e.fv);
        chk("fail_a", int'(fail_a), e.fa);
        chk("fail_b", int'(fail_b), e.fb);
        chk("busy at done", int'(busy), 0);
        chk("a_out held", int'(a_out), 15);
        chk("b_out held", int'(b_out), 15);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Correct comparator.
    run_sweep(0, 0, 0, 0, 1'b0);
    // Equal stuck at 0: 16 diagonal vectors fail, first at (0,0).
    run_sweep(1, 16, 0, 0, 1'b0);
    // Greater/less swapped: 256-16 off-diagonal vectors fail, first at (0,1).
    run_sweep(2, 240, 0, 1, 1'b0);
    // Start re-pulsed mid-sweep must be ignored.
    run_sweep(0, 0, 0, 0, 1'b1);

    // Reset mid-sweep after a faulty run: everything clears, no done.
    mode = 1;
    tick();
    pulse_start();
    repeat (299) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_all_zero("mid-sweep reset");
    run_sweep(0, 0, 0, 0, 1'b0);

    repeat (3) tick();
    chk("pending expectations", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
